// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ---------------
// Shares one UART transmitter between NUM_REQ byte requesters using a
// round-robin arbiter that grants one byte per grant, and owns the
// send / data / tx_ready handshake towards the UART.
//
// Handshake summary (all signals sampled on the rising clock edge):
//   requester side: req[i] is a level held until ack[i]; req_data slice i is
//     stable while req[i]=1. ack[i] is a one-cycle pulse in the cycle after
//     the byte was latched. The requester drops req[i] or presents its next
//     byte in the cycle after ack; a req still high is simply a new request.
//   uart side: send is a one-cycle pulse, asserted one cycle after ack, while
//     data_out already holds the byte. tx_ready=1 means the UART is idle; the
//     arbiter waits for tx_ready to fall (transfer started) and then to rise
//     again (transfer done) before granting the next byte.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   req          per-requester request level
//   req_data     requester i byte at [i*CHAR_WIDTH +: CHAR_WIDTH]
//   ack          one-cycle grant pulse to the requester whose byte was latched
//   tx_ready     UART idle flag
//   send         one-cycle start pulse to the UART
//   data_out     byte to the UART, held from grant until the next grant
//   busy         high whenever the FSM is not IDLE
//   grant_id     index of the current or last granted requester
//   timeout_err  sticky flag: tx_ready never fell after a send
//   clear_err    synchronous clear of timeout_err (a same-cycle set wins)
//   state_dbg    current FSM state (IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3)

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int CHAR_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req,
  input  logic [NUM_REQ*CHAR_WIDTH-1:0]                 req_data,
  output logic [NUM_REQ-1:0]                            ack,
  input  logic                                          tx_ready,
  output logic                                          send,
  output logic [CHAR_WIDTH-1:0]                         data_out,
  output logic                                          busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                          timeout_err,
  input  logic                                          clear_err,
  output logic [1:0]                                    state_dbg
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] RR_RESET     = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    send_q, send_d;
  logic [CHAR_WIDTH-1:0]   data_q, data_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           rr_q, rr_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic                    any_win;
  logic [GW-1:0]           win_idx;
  int                      cand;
  logic                    grant_now;
  logic                    timeout_hit;

  // Round-robin pick: scan rr+1, rr+2, ... modulo NUM_REQ. The loop walks
  // from the farthest offset to the nearest so the nearest set req is the
  // last assignment and therefore wins.
  always_comb begin
    any_win = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = (int'(rr_q) + i) % NUM_REQ;
      if (req[cand]) begin
        any_win = 1'b1;
        win_idx = GW'(cand);
      end
    end
  end

  assign grant_now   = (state_q == IDLE) && any_win && tx_ready;
  // Last counted cycle of WAIT_BUSY with tx_ready still high.
  assign timeout_hit = (state_q == WAIT_BUSY) && tx_ready && (cnt_q == TIMEOUT_LAST);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_now) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_ready)        state_d = WAIT_DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      WAIT_DONE: if (tx_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath logic. ack and send are registered so both are clean
  // flop outputs: ack appears in the ISSUE cycle, and the send pulse is
  // launched from ISSUE so it appears one cycle later, never overlapping ack.
  always_comb begin
    ack_d   = '0;
    send_d  = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (clear_err) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_now) begin
          ack_d[win_idx] = 1'b1;
          data_d         = req_data[win_idx*CHAR_WIDTH +: CHAR_WIDTH];
          grant_d        = win_idx;
          rr_d           = win_idx;
        end
      end
      ISSUE: begin
        send_d = 1'b1;
        cnt_d  = '0;
      end
      WAIT_BUSY: begin
        if (tx_ready) cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase

    // A timeout in the same cycle as clear_err leaves the flag set.
    if (timeout_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      rr_q    <= RR_RESET;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      send_q  <= send_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ack         = ack_q;
  assign send        = send_q;
  assign data_out    = data_q;
  assign grant_id    = grant_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed stimulus with a scoreboard of
// expected ack vectors and bytes, a negedge monitor that pops and compares,
// and a simple UART model driving tx_ready.

module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 3;
  localparam int CW      = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*CW-1:0]   req_data;
  logic [NUM_REQ-1:0]      ack;
  logic                    tx_ready;
  logic                    send;
  logic [CW-1:0]           data_out;
  logic                    busy;
  logic [1:0]              grant_id;
  logic                    timeout_err;
  logic                    clear_err;
  logic [1:0]              state_dbg;

  logic                    uart_ready;
  logic                    hold_low;
  logic                    no_drop;
  int                      busy_len;

  int checks     = 0;
  int errors     = 0;
  int send_count = 0;

  logic [NUM_REQ-1:0] exp_ack_q[$];
  logic [CW-1:0]      exp_q[$];

  assign tx_ready = uart_ready && !hold_low;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .CHAR_WIDTH(CW), .BUSY_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_ready    (tx_ready),
    .send        (send),
    .data_out    (data_out),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .clear_err   (clear_err),
    .state_dbg   (state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // UART model: drops tx_ready two cycles after send, keeps it low busy_len cycles.
  initial begin
    uart_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (send === 1'b1 && !no_drop) begin
        repeat (2) @(posedge clk);
        #1 uart_ready = 1'b0;
        repeat (busy_len) @(posedge clk);
        #1 uart_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents ack or send.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (ack != '0 || send) begin
        checks++;
        if (ack != '0 && send) begin
          errors++;
          $display("FAIL ack_send_overlap ack=%b send=%b required send=0 while ack", ack, send);
        end
      end
      if (ack != '0) begin
        checks++;
        if (exp_ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected got=%b required none", ack);
        end else begin
          logic [NUM_REQ-1:0] ea;
          ea = exp_ack_q.pop_front();
          if (ack !== ea) begin
            errors++;
            $display("FAIL ack_order got=%b required=%b", ack, ea);
          end
        end
      end
      if (send) begin
        send_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL send_unexpected data=%h required none", data_out);
        end else begin
          logic [CW-1:0] ed;
          ed = exp_q.pop_front();
          if (data_out !== ed) begin
            errors++;
            $display("FAIL send_data got=%h required=%h", data_out, ed);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req_v);
    checks++;
    if (got !== req_v) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req_v);
    end
  endtask

  task automatic expect_grant(input logic [NUM_REQ-1:0] a, input logic [CW-1:0] d);
    exp_ack_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic wait_ack(input int limit);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (ack == '0 && n < limit);
    if (ack == '0) begin
      checks++; errors++;
      $display("FAIL wait_ack timed out after %0d cycles required an ack", limit);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!(busy == 1'b0 && tx_ready == 1'b1) && n < limit) begin
      step();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL wait_idle timed out busy=%b required 0", busy);
    end
  endtask

  task automatic wait_tx(input logic level, input int limit);
    int n;
    n = 0;
    while (tx_ready !== level && n < limit) begin
      step();
      n++;
    end
    if (tx_ready !== level) begin
      checks++; errors++;
      $display("FAIL wait_tx tx_ready=%b required=%b", tx_ready, level);
    end
  endtask

  // Issue a request whose UART never answers; expect timeout 16 cycles after send.
  task automatic do_timeout(input int idx, input logic [CW-1:0] d);
    int k;
    no_drop = 1'b1;
    req = '0;
    req[idx] = 1'b1;
    req_data[idx*CW +: CW] = d;
    expect_grant(NUM_REQ'(1 << idx), d);
    wait_ack(50);
    req = '0;
    step();
    check("timeout_send", {31'd0, send}, 32'd1);
    k = 0;
    while (timeout_err !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check("timeout_cycles", k, 32'd16);
    check("timeout_idle", {31'd0, busy}, 32'd0);
    no_drop = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    req       = '0;
    req_data  = '0;
    clear_err = 1'b0;
    hold_low  = 1'b0;
    no_drop   = 1'b0;
    busy_len  = 20;

    // Reset with all requests high
    req      = 3'b111;
    req_data = {8'h13, 8'h12, 8'h11};
    repeat (3) step();
    check("rst_send", {31'd0, send}, 32'd0);
    check("rst_ack", {29'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_grant", {30'd0, grant_id}, 32'd0);
    check("rst_err", {31'd0, timeout_err}, 32'd0);
    expect_grant(3'b001, 8'h11);
    reset = 1'b1;
    step();
    check("first_ack", {29'd0, ack}, 32'b001);
    req = '0;
    step();
    check("first_send", {31'd0, send}, 32'd1);
    check("first_data", {24'd0, data_out}, 32'h11);
    wait_idle(200);

    // Single requester
    begin
      int s0;
      s0 = send_count;
      req = 3'b010;
      req_data = {8'h00, 8'h41, 8'h00};
      expect_grant(3'b010, 8'h41);
      wait_ack(50);
      req = '0;
      wait_tx(1'b0, 50);
      wait_tx(1'b1, 50);
      step();
      check("single_busy_after_ready", {31'd0, busy}, 32'd0);
      check("single_send_count", send_count - s0, 32'd1);
      check("single_data_held", {24'd0, data_out}, 32'h41);
      check("single_grant", {30'd0, grant_id}, 32'd1);
    end

    // Round-robin after a fresh reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    busy_len = 6;
    req = 3'b111;
    req_data = {8'h32, 8'h31, 8'h30};
    for (int r = 0; r < 6; r++)
      expect_grant(NUM_REQ'(1 << (r % 3)), 8'h30 + 8'(r % 3));
    for (int r = 0; r < 6; r++) begin
      wait_ack(100);
      if (r == 5) req = '0;
    end
    wait_idle(200);

    // tx_ready low in IDLE blocks grants
    hold_low = 1'b1;
    req = 3'b100;
    req_data = {8'h55, 8'h00, 8'h00};
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        step();
        if (ack != '0 || send) bad++;
      end
      check("ready_low_no_grant", bad, 32'd0);
    end
    expect_grant(3'b100, 8'h55);
    hold_low = 1'b0;
    step();
    check("ready_high_ack2", {29'd0, ack}, 32'b100);
    req = '0;
    wait_idle(200);

    // Timeout, then normal service, then clear
    do_timeout(0, 8'h66);
    req = 3'b010;
    req_data = {8'h00, 8'h77, 8'h00};
    expect_grant(3'b010, 8'h77);
    wait_ack(50);
    req = '0;
    wait_idle(200);
    check("err_sticky", {31'd0, timeout_err}, 32'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("err_cleared", {31'd0, timeout_err}, 32'd0);

    // clear_err held through a timeout: set wins
    clear_err = 1'b1;
    do_timeout(2, 8'h99);
    clear_err = 1'b0;
    check("err_set_wins", {31'd0, timeout_err}, 32'd1);
    step();
    check("err_sticky2", {31'd0, timeout_err}, 32'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;

    // Reset mid-transfer
    busy_len = 20;
    req = 3'b100;
    req_data = {8'hAA, 8'h00, 8'h00};
    expect_grant(3'b100, 8'hAA);
    wait_ack(50);
    req = '0;
    wait_tx(1'b0, 50);
    step();
    check("mid_state_wait_done", {30'd0, state_dbg}, 32'd3);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_send", {31'd0, send}, 32'd0);
    check("mid_rst_ack", {29'd0, ack}, 32'd0);
    check("mid_rst_data", {24'd0, data_out}, 32'd0);
    step();
    reset = 1'b1;
    req = 3'b111;
    req_data = {8'hC3, 8'hC2, 8'hC1};
    expect_grant(3'b001, 8'hC1);
    wait_ack(100);
    req = '0;
    wait_idle(200);
    check("mid_restart_grant", {30'd0, grant_id}, 32'd0);

    // Final report
    repeat (3) step();
    check("ack_queue_empty", exp_ack_q.size(), 32'd0);
    check("data_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte requesters (e.g. switch/button ASCII sender, RX echo path, status-message generator).
- Round-robin arbitration, one byte per grant.
- Owns the UART send/data_transmit/tx_ready handshake, so requesters never drive the UART directly.
- Sits between the requester blocks and the uart instance in the top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- CHAR_WIDTH, 8, byte width.
- BUSY_TIMEOUT, 16, max cycles after send to wait for tx_ready to fall before forcing completion.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester request level; held until matching ack
- req_data  input  NUM_REQ*CHAR_WIDTH  requester i byte at bits [i*CHAR_WIDTH +: CHAR_WIDTH]; stable while req[i]=1
- ack  output  NUM_REQ  one-cycle pulse to the requester whose byte was latched
- tx_ready  input  1  from uart; 1 = transmitter idle
- send  output  1  one-cycle pulse to uart
- data_out  output  CHAR_WIDTH  byte to uart; held stable from send until completion
- busy  output  1  1 whenever state != IDLE
- grant_id  output  $clog2(NUM_REQ) (minimum 1)  index of current or last granted requester
- timeout_err  output  1  sticky; set on busy timeout
- clear_err  input  1  synchronous clear of timeout_err

Behaviour:
- Reset (reset=0, asynchronous):
  - outputs: send=0, ack=0, data_out=0, busy=0, grant_id=0, timeout_err=0.
  - internal: state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transfer aborts immediately; no ack is issued for the aborted byte.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req=1 and tx_ready=1, select the first set req scanning rr_ptr+1, rr_ptr+2, ... with modulo NUM_REQ wrap.
  - On the select edge: latch req_data of the winner into data_out, set grant_id and rr_ptr to the winner, pulse ack[winner], go to ISSUE.
  - If tx_ready=0, stay in IDLE with no grant.
- ISSUE:
  - send=1 for exactly this one cycle.
  - Clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_ready=0 -> WAIT_DONE.
  - Otherwise count up; when the count reaches BUSY_TIMEOUT, set timeout_err and go to IDLE.
- WAIT_DONE:
  - tx_ready=1 -> IDLE.
  - No timeout in this state; the byte time is owned by the uart.
- Latency:
  - req rising (with tx_ready=1, IDLE) -> ack pulse on the next clock edge.
  - send asserts one cycle after ack.
  - Minimum spacing between grants is 4 cycles plus the uart byte time.
- Requester contract:
  - Deassert req, or present the next byte, in the cycle after ack.
  - A req still high after ack is treated as a new request and competes normally.
- Fairness: with all req held high, grants rotate 0,1,2,0,... with no requester granted twice while another is waiting.
- Simultaneous events:
  - clear_err and a timeout in the same cycle: set wins.
  - req changes during non-IDLE states are ignored until IDLE.
- ack and send are never high in the same cycle; at most one ack bit is high per cycle.
- data_out holds its value after completion until the next grant.

Test Plan:
- Reset: hold reset=0 with req=3'b111 -> send=0, ack=0, busy=0; release, tx_ready=1 -> ack=3'b001 on the first edge and send next cycle with data_out=req_data[7:0].
- Single requester: req[1]=1, data 8'h41, uart model drops tx_ready 2 cycles after send for 20 cycles -> exactly one send, data_out=8'h41, busy=0 one cycle after tx_ready returns.
- Round-robin: req=3'b111 held, bytes 8'h30/8'h31/8'h32 -> uart sees 30,31,32,30,31,32; ack order 001,010,100 repeating.
- tx_ready low in IDLE: req[2]=1 while tx_ready=0 for 10 cycles -> no ack, no send; tx_ready=1 -> ack[2] next edge.
- Timeout: uart model never drops tx_ready -> after send plus BUSY_TIMEOUT (16) cycles timeout_err=1 and state returns to IDLE; next request still serviced; clear_err=1 -> timeout_err=0 next edge.
- Reset mid-transfer: assert reset in WAIT_DONE -> busy, send and ack go 0 asynchronously; after release, arbitration restarts from requester 0.
